mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single shared, multi-cycle, pipelined main memory between the I-cache miss handler and the D-cache miss/store path.
- Grants one requester at a time.
- For a miss, performs an 8-word block fill and streams the returned words back to the owner.
- For a store, performs a single write-through cycle.
- Sits between both caches and main memory, below the fetch and memory pipeline stages.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block (16 bytes); fill and issue counters are clog2 of this wide.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- i_req  in  1  I-cache miss request; held until i_done.
- i_addr  in  16  I-cache miss byte address.
- d_req  in  1  D-cache request; held until d_done.
- d_wr  in  1  qualifies d_req: 1 = store (write-through), 0 = miss fill.
- d_addr  in  16  D-cache byte address.
- d_wdata  in  16  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  mem_rdata valid; read returns arrive in issue order.
- fill_data  out  16  returned word, shared by both caches.
- fill_word  out  3  word index within the block.
- i_fill_we  out  1  I-cache data-array write enable.
- d_fill_we  out  1  D-cache data-array write enable.
- i_done  out  1  one-cycle pulse: I fill complete.
- d_done  out  1  one-cycle pulse: D fill or store complete.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; issue_cnt=0; recv_cnt=0; base=0; last_d=0. All outputs 0 from the cycle after rst is sampled high.
- Reset mid-operation aborts the current access. Any later mem_valid is ignored because the block is in IDLE.
- States:
  - IDLE, D_FILL, I_FILL, D_WRITE.
  - IDLE performs arbitration only and drives no memory access; the next state is registered.
- Arbitration in IDLE:
  - d_req&d_wr -> D_WRITE.
  - d_req&~d_wr&~(last_d&i_req) -> D_FILL.
  - i_req -> I_FILL.
  - Otherwise stay in IDLE.
  - Stores always win. Fills alternate when both caches miss, so the I-cache is not starved.
- Grant side effects:
  - base = addr & 16'hFFF0 for fills.
  - last_d = 1 on a D_FILL grant, 0 on an I_FILL grant; unchanged by D_WRITE.
- D_WRITE (one cycle):
  - mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1.
  - Next state IDLE.
- Fill states, issue side:
  - While issue_cnt<8: mem_en=1, mem_wr=0, mem_addr=base+{issue_cnt,1'b0}; issue_cnt increments.
  - Issue occupies 8 consecutive cycles with no gaps.
- Fill states, receive side:
  - On mem_valid: fill_data=mem_rdata and fill_word=recv_cnt. The owner's fill_we is 1, combinational from mem_valid. recv_cnt increments.
  - When mem_valid and recv_cnt==7: the owner's done pulses in the same cycle; the next state is IDLE and both counters clear.
- Issue and receive overlap. The block does not depend on memory latency.
- mem_valid in IDLE or D_WRITE is ignored: no fill_we, no counter change.
- Requester contract: drop req in the cycle after its done. A req still high in IDLE after done is treated as a new request.
- With a 4-cycle memory:
  - Request seen in IDLE at cycle 0.
  - Issues in cycles 1–8.
  - Data returns in cycles 5–12.
  - done at cycle 12; arbitration resumes at cycle 13.
- Non-owner fill_we and done are always 0.
- fill_data/fill_word are don't-care when both fill_we are 0; they are driven 0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, D_FILL, I_FILL, D_WRITE);
  - WORDS_PER_BLOCK;
  - BLOCK_MASK = 16'hFFF0;
  - WORD_IDX_W = 3.
- One sub-module is natural: mem_arb_counter, a 3-bit saturating counter with clear/inc/done, instantiated twice (issue and receive).

Test Plan:
- Single I fill: i_req=1, i_addr=16'h0046; memory latency 4 returns 16'h1000+k -> mem_addr 0x0040, 0x0042 … 0x004E in cycles 1–8; i_fill_we pulses cycles 5–12 with fill_word 0..7 and fill_data 0x1000..0x1007; i_done at cycle 12; d_fill_we stays 0.
- Store priority: d_req=1, d_wr=1, d_addr=0x0120, d_wdata=0xBEEF, with i_req=1 in the same cycle -> D_WRITE first (mem_wr=1, addr 0x0120, data 0xBEEF, d_done one cycle), then I_FILL.
- Alternation: both fill requests held continuously -> grant order D_FILL, I_FILL, D_FILL; each completion is exactly 8 fill_we pulses for its owner.
- Stray data: mem_valid pulses while in IDLE -> no fill_we, no done, recv_cnt stays 0.
- Reset mid-fill: rst high for 1 cycle after 3 words received -> next cycle busy=0 and all outputs 0; trailing mem_valid ignored. A new i_req then refills from word 0.
- Back-to-back: i_req still high the cycle after i_done (new address 0x0080) -> IDLE for one cycle, then a fresh fill at 0x0080.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter between the I-cache and D-cache.
package mem_arb_pkg;

  localparam int          WORDS_PER_BLOCK = 8;
  localparam int          WORD_IDX_W      = 3;
  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_FILL  = 2'd1,
    I_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arb_counter.sv
// Saturating word counter: counts up to LAST, then raises done and holds until cleared.
module mem_arb_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);

  localparam logic [W-1:0] LAST_C = W'(LAST);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (inc_i && !done_q) begin
      if (cnt_q == LAST_C) done_d = 1'b1;
      else                 cnt_d  = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared pipelined main memory between I-cache fills, D-cache fills
// and D-cache write-through stores; streams fill words back to the owning cache.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_req,
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic                               d_req,
  input  logic                               d_wr,
  input  logic [ADDR_W-1:0]                  d_addr,
  input  logic [DATA_W-1:0]                  d_wdata,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  input  logic [DATA_W-1:0]                  mem_rdata,
  input  logic                               mem_valid,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [mem_arb_pkg::WORD_IDX_W-1:0] fill_word,
  output logic                               i_fill_we,
  output logic                               d_fill_we,
  output logic                               i_done,
  output logic                               d_done,
  output logic                               busy
);

  import mem_arb_pkg::*;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  last_d_q, last_d_d;
  logic [WORD_IDX_W-1:0] issue_cnt, recv_cnt;
  logic                  issue_done, recv_done;
  logic                  in_fill, issuing, accept, fill_last;

  assign in_fill   = (state_q == D_FILL) || (state_q == I_FILL);
  assign issuing   = in_fill && !issue_done;
  assign accept    = in_fill && mem_valid && !recv_done;
  assign fill_last = accept && (recv_cnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

  mem_arb_counter #(.W(WORD_IDX_W), .LAST(WORDS_PER_BLOCK - 1)) u_issue_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (fill_last),
    .inc_i (issuing),
    .cnt_o (issue_cnt),
    .done_o(issue_done)
  );

  mem_arb_counter #(.W(WORD_IDX_W), .LAST(WORDS_PER_BLOCK - 1)) u_recv_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (fill_last),
    .inc_i (accept),
    .cnt_o (recv_cnt),
    .done_o(recv_done)
  );

  // Stores always win; last_d flips fill priority so neither cache starves.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (d_req && d_wr) begin
          state_d = D_WRITE;
        end else if (d_req && !(last_d_q && i_req)) begin
          state_d  = D_FILL;
          base_d   = d_addr & ADDR_W'(BLOCK_MASK);
          last_d_d = 1'b1;
        end else if (i_req) begin
          state_d  = I_FILL;
          base_d   = i_addr & ADDR_W'(BLOCK_MASK);
          last_d_d = 1'b0;
        end
      end
      D_WRITE: state_d = IDLE;
      default: if (fill_last) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    mem_en    = issuing || (state_q == D_WRITE);
    mem_wr    = (state_q == D_WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == D_WRITE) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (issuing) begin
      mem_addr = base_q + {{(ADDR_W - WORD_IDX_W - 1){1'b0}}, issue_cnt, 1'b0};
    end
  end

  assign fill_data = accept ? mem_rdata : '0;
  assign fill_word = accept ? recv_cnt  : '0;
  assign i_fill_we = accept && (state_q == I_FILL);
  assign d_fill_we = accept && (state_q == D_FILL);
  assign i_done    = fill_last && (state_q == I_FILL);
  assign d_done    = (fill_last && (state_q == D_FILL)) || (state_q == D_WRITE);
  assign busy      = (state_q != IDLE);

endmodule
